// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths and the memtoReg encodings used by the
// control unit, the MEM/WB register and the writeback stage.
package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_PC4 = 2'b10,
    WB_SEL_RSV = 2'b11
  } wb_sel_e;

  // Fields carried by the MEM/WB pipeline register into writeback.
  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic                  reg_write;
    wb_sel_e               sel;
    logic [XLEN-1:0]       mem_data;
    logic [XLEN-1:0]       alu_out;
    logic [REG_ADDR_W-1:0] rd;
  } memwb_t;

endpackage

// File: rtl/wb_mux.sv
// Writeback value selector: ALU result, load data or link address (PC+4).
module wb_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = pipe_pkg::XLEN
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] wb_data
);

  always_comb begin
    wb_data = alu_out;
    case (wb_sel_e'(sel))
      WB_SEL_MEM: wb_data = mem_data;
      // Link address wraps naturally at XLEN bits.
      WB_SEL_PC4: wb_data = pc + XLEN'(4);
      default:    wb_data = alu_out;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the MEM/WB result, commits it to the integer
// register file, serves the two ID read ports with bypass, counts retirements.
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int XLEN  = pipe_pkg::XLEN,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [XLEN-1:0]       PC_in,
  input  logic                  regWrite_in,
  input  logic [1:0]            memtoReg_in,
  input  logic [XLEN-1:0]       readMemData_in,
  input  logic [XLEN-1:0]       ALUOut_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_we,
  output logic [CNT_W-1:0]      retire_cnt
);

  localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int NUM_RD = 2;

  logic [NREG-1:0][XLEN-1:0]   regs;
  logic [AW-1:0]               rd_idx;
  logic [NUM_RD-1:0][AW-1:0]   rs_idx;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;

  wb_mux #(.XLEN(XLEN)) u_wb_mux (
    .sel      (memtoReg_in),
    .pc       (PC_in),
    .mem_data (readMemData_in),
    .alu_out  (ALUOut_in),
    .wb_data  (wb_data)
  );

  assign rd_idx    = AW'(32'(rd_in) % NREG);
  assign rs_idx[0] = AW'(32'(rs1_addr) % NREG);
  assign rs_idx[1] = AW'(32'(rs2_addr) % NREG);

  // A bubble or a write to x0 never strobes, so bypass and count follow too.
  assign wb_we = wb_valid & regWrite_in & (rd_idx != '0);

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    always_comb begin
      rd_data[p] = regs[rs_idx[p]];
      if (rs_idx[p] == '0)
        rd_data[p] = '0;
      else if (wb_we && rs_idx[p] == rd_idx)
        rd_data[p] = wb_data;
    end
  end

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      regs       <= '0;
      retire_cnt <= '0;
    end else if (wb_we) begin
      regs[rd_idx] <= wb_data;
      retire_cnt   <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] PC_in;
  logic        regWrite_in;
  logic [1:0]  memtoReg_in;
  logic [31:0] readMemData_in;
  logic [31:0] ALUOut_in;
  logic [4:0]  rd_in, rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data, retire_cnt;
  logic        wb_we;
  logic [31:0] rs1_data4, rs2_data4, wb_data4;
  logic        wb_we4;
  logic [3:0]  retire_cnt4;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .PC_in(PC_in),
    .regWrite_in(regWrite_in), .memtoReg_in(memtoReg_in),
    .readMemData_in(readMemData_in), .ALUOut_in(ALUOut_in), .rd_in(rd_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .wb_data(wb_data), .wb_we(wb_we),
    .retire_cnt(retire_cnt)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .PC_in(PC_in),
    .regWrite_in(regWrite_in), .memtoReg_in(memtoReg_in),
    .readMemData_in(readMemData_in), .ALUOut_in(ALUOut_in), .rd_in(rd_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data4),
    .rs2_data(rs2_data4), .wb_data(wb_data4), .wb_we(wb_we4),
    .retire_cnt(retire_cnt4)
  );

  typedef struct {
    string       name;
    logic [31:0] rs1, rs2, wbd, cnt;
    logic        we;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  function automatic void cmp(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, "rs1_data", rs1_data, e.rs1);
      cmp(e.name, "rs2_data", rs2_data, e.rs2);
      cmp(e.name, "wb_data", wb_data, e.wbd);
      cmp(e.name, "wb_we", {31'b0, wb_we}, {31'b0, e.we});
      cmp(e.name, "retire_cnt", retire_cnt, e.cnt);
      cmp(e.name, "retire_cnt4", {28'b0, retire_cnt4}, {28'b0, e.cnt[3:0]});
      cmp(e.name, "rs1_data4", rs1_data4, e.rs1);
    end
  end

  task automatic step(input string nm, input logic r, input logic v,
                      input logic [31:0] pc, input logic rw, input logic [1:0] sel,
                      input logic [31:0] mem, input logic [31:0] alu,
                      input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] ewb, input logic ewe);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; wb_valid = v; PC_in = pc; regWrite_in = rw; memtoReg_in = sel;
    readMemData_in = mem; ALUOut_in = alu; rd_in = rd; rs1_addr = a1; rs2_addr = a2;
    e.name = nm; e.rs1 = e1; e.rs2 = e2; e.wbd = ewb; e.we = ewe; e.cnt = model_cnt;
    q.push_back(e);
    if (r) model_cnt = 0;
    else if (ewe) model_cnt++;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 0; PC_in = 0; regWrite_in = 0; memtoReg_in = 0;
    readMemData_in = 0; ALUOut_in = 0; rd_in = 0; rs1_addr = 0; rs2_addr = 0;
    repeat (2) @(posedge clk);
    //    name        rst v  pc            rw sel    mem     alu          rd a1 a2  e1            e2     ewb           we
    step("w_x5",      0, 1, 32'h0,        1, 2'b00, 32'h0,  32'h12345678, 5, 5, 0, 32'h12345678, 32'h0, 32'h12345678, 1);
    step("rst_hold",  1, 0, 32'h0,        0, 2'b00, 32'h0,  32'h0,        0, 5, 0, 32'h12345678, 32'h0, 32'h0,        0);
    step("rst_clr",   0, 0, 32'h0,        0, 2'b00, 32'h0,  32'h0,        0, 5, 0, 32'h0,        32'h0, 32'h0,        0);
    step("sel_alu",   0, 1, 32'h0,        1, 2'b00, 32'h9,  32'hA,        3, 3, 5, 32'hA,        32'h0, 32'hA,        1);
    step("sel_mem",   0, 1, 32'h0,        1, 2'b01, 32'hB,  32'h777,      4, 3, 4, 32'hA,        32'hB, 32'hB,        1);
    step("sel_pc4",   0, 1, 32'h100,      1, 2'b10, 32'h1,  32'h2,        1, 4, 1, 32'hB,        32'h104, 32'h104,    1);
    step("pc4_wrap",  0, 1, 32'hFFFFFFFC, 1, 2'b10, 32'h1,  32'h99,       6, 1, 6, 32'h104,      32'h0, 32'h0,        1);
    step("sel_rsv",   0, 1, 32'h200,      1, 2'b11, 32'h33, 32'h11,       7, 6, 3, 32'h0,        32'hA, 32'h11,       1);
    step("byp_nowr",  0, 1, 32'h0,        0, 2'b00, 32'h0,  32'h22,       7, 7, 7, 32'h11,       32'h11, 32'h22,      0);
    step("byp_both",  0, 1, 32'h0,        1, 2'b00, 32'h0,  32'h22,       7, 7, 7, 32'h22,       32'h22, 32'h22,      1);
    step("x0_write",  0, 1, 32'h0,        1, 2'b00, 32'h0,  32'hDEAD,     0, 0, 7, 32'h0,        32'h22, 32'hDEAD,    0);
    step("bubble",    0, 0, 32'h0,        1, 2'b00, 32'h0,  32'h55,       9, 0, 9, 32'h0,        32'h0, 32'h55,       0);
    step("bub_read",  0, 0, 32'h0,        0, 2'b00, 32'h0,  32'h0,        0, 9, 0, 32'h0,        32'h0, 32'h0,        0);
    step("rst_prio",  1, 1, 32'h0,        1, 2'b00, 32'h0,  32'h77,       2, 2, 0, 32'h77,       32'h0, 32'h77,       1);
    step("prio_read", 0, 0, 32'h0,        0, 2'b00, 32'h0,  32'h0,        0, 2, 7, 32'h0,        32'h0, 32'h0,        0);
    for (int i = 0; i < 16; i++)
      step("wrap_wr", 0, 1, 32'h0, 1, 2'b00, 32'h0, 32'(i + 1), 5'(10 + i % 4),
           5'(10 + i % 4), 0, 32'(i + 1), 32'h0, 32'(i + 1), 1);
    step("wrap_chk",  0, 0, 32'h0,        0, 2'b00, 32'h0,  32'h0,        0, 13, 10, 32'h10,     32'hD, 32'h0,        0);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register.
- Selects the writeback value from the MEM/WB fields, then commits it to a 32x32 integer register file.
- Serves the two ID-stage read ports, with same-cycle write-to-read bypass.
- Also keeps a retired-writeback counter for debug and CPI measurement.

Parameters:
- XLEN, 32, data width of registers, PC and writeback value.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- wb_valid  input  1  MEM/WB slot holds a real instruction (0 = bubble)
- PC_in  input  XLEN  PC of the instruction in WB
- regWrite_in  input  1  write enable from MEM/WB
- memtoReg_in  input  2  writeback select from MEM/WB
- readMemData_in  input  XLEN  load data from MEM/WB
- ALUOut_in  input  XLEN  ALU result from MEM/WB
- rd_in  input  5  destination register from MEM/WB
- rs1_addr  input  5  ID read port 1 address
- rs2_addr  input  5  ID read port 2 address
- rs1_data  output  XLEN  read port 1 data (combinational)
- rs2_data  output  XLEN  read port 2 data (combinational)
- wb_data  output  XLEN  selected writeback value (combinational, for forwarding)
- wb_we  output  1  effective write strobe this cycle
- retire_cnt  output  CNT_W  count of committed register writes

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- On reset, at the clk edge with rst=1: all registers clear to 0 and retire_cnt clears to 0. No write commits in that cycle, even if wb_we=1.
- Writeback select (combinational):
  - memtoReg 2'b00 selects ALUOut_in.
  - 2'b01 selects readMemData_in.
  - 2'b10 selects PC_in+4, computed modulo 2^XLEN, so PC 0xFFFFFFFC gives 0x00000000.
  - 2'b11 is reserved and selects ALUOut_in.
- Write strobe: wb_we = wb_valid & regWrite_in & (rd_in != 0).
- Commit: when wb_we=1 and rst=0, reg[rd_in] takes wb_data at the rising clk edge. Write latency is one edge.
- Register 0: writes to register 0 are dropped. Reading register 0 always returns 0, including through the bypass.
- Read ports:
  - Asynchronous reads of the array.
  - Bypass: if wb_we=1 and rsX_addr==rd_in and rsX_addr!=0, then rsX_data=wb_data, the value being written this cycle. This covers the WB-to-ID hazard without a half-cycle clock.
  - Both ports may bypass in the same cycle.
  - Identical rs1/rs2 addresses return identical data.
- Bubbles: wb_valid=0 suppresses the write, the bypass and the count, whatever the other fields hold.
- retire_cnt: increments by 1 on every edge where wb_we=1 and rst=0. It wraps from 2^CNT_W-1 to 0 with no saturation.
- rd_in and the rs addresses are used mod NREG. With NREG=32 all 5-bit values are valid.
- No stall input: the upstream MEM/WB register freezes its own outputs. A stalled, repeated slot must arrive with wb_valid=0 or it is counted again.

Decomposition:
- Shared package pipe_pkg holds:
  - memtoReg encodings: WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10.
  - XLEN and REG_ADDR_W=5.
- Also in pipe_pkg: the same encodings used by the control unit and the MEM/WB register, so all three stay aligned.
- One natural sub-module, wb_mux: the pure combinational writeback selector. wb_regfile contains the array, the bypass and the counter.

Test Plan:
- Reset clears the state: write 0x12345678 to x5, then rst=1 for one edge. Next cycle rs1_addr=5 gives rs1_data=0 and retire_cnt=0.
- Select paths:
  - ALUOut=0xA, memtoReg=00, rd=3 gives reg x3=0xA.
  - readMemData=0xB, memtoReg=01, rd=4 gives reg x4=0xB.
  - PC=0x100, memtoReg=10, rd=1 gives reg x1=0x104.
  - PC=0xFFFFFFFC, memtoReg=10 writes 0x0.
  - retire_cnt steps by 1 per write.
- Same-cycle bypass:
  - With x7=0x11 stored, write x7=0x22 while rs1_addr=rs2_addr=7. Both ports read 0x22 in that cycle.
  - With regWrite_in=0 instead, both ports read 0x11.
- x0 guard: write 0xDEAD to rd=0 with rs1_addr=0 gives rs1_data=0, wb_we=0 and no count; the next cycle still reads 0.
- Bubble: wb_valid=0 with regWrite=1, rd=9, ALUOut=0x55 leaves x9 unchanged, gives no bypass to rs2_addr=9, and retire_cnt does not change.
- Wrap and reset priority:
  - Counter wrap: with CNT_W=4, 16 valid writes return retire_cnt to 0.
  - Reset priority: rst=1 together with a valid write to x2 leaves x2=0.
